// File: rtl/cronometro_pkg.sv
// Shared constants for the stopwatch input conditioner.
// Holds the clock rate, the debounce and stretch times, the cycle counts
// derived from them, the default button polarity, and a counter-width helper.
package cronometro_pkg;
  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 10;
  localparam int STRETCH_MS  = 50;

  localparam int DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS; // 500000
  localparam int STRETCH_CYCLES_DEF  = (CLK_HZ / 1000) * STRETCH_MS;  // 2500000

  // Board KEY buttons read 0 while pressed
  localparam bit BTN_ACTIVE_LOW_DEF = 1'b1;

  // Slide-switch channels: mode0, mode1, pause, pio
  localparam int NUM_SW = 4;

  // Width of a counter that must hold 0..n-1. It is never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cronometro_input_cond_if.sv
// Board-side bundle for the input conditioner.
// The raw pin levels enter the block and the conditioned PIO levels leave it.
//   slave  : the conditioner. It reads the raw pins and drives the PIO levels.
//   master : the board or bench. It drives the raw pins and reads the PIO levels.
interface cronometro_input_cond_if;
  logic sw_mode0_raw;
  logic sw_mode1_raw;
  logic sw_pause_raw;
  logic sw_pio_raw;
  logic btn_play_raw;
  logic switch_mode0;
  logic switch_mode1;
  logic switch_pause;
  logic pio_switch;
  logic play_btn;
  logic play_evt;

  modport slave (
    input  sw_mode0_raw, sw_mode1_raw, sw_pause_raw, sw_pio_raw, btn_play_raw,
    output switch_mode0, switch_mode1, switch_pause, pio_switch, play_btn, play_evt
  );

  modport master (
    output sw_mode0_raw, sw_mode1_raw, sw_pause_raw, sw_pio_raw, btn_play_raw,
    input  switch_mode0, switch_mode1, switch_pause, pio_switch, play_btn, play_evt
  );
endinterface

// File: rtl/debounce_ch.sv
// One input channel: a 2-flop synchroniser followed by a debouncer.
// The debouncer accepts a new level after DEBOUNCE_CYCLES consecutive edges
// that disagree with the held level.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low
//   din   : raw level, asynchronous to clk
//   dout  : debounced level, driven straight from the held-level flop
module debounce_ch
  import cronometro_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= {2{RESET_LEVEL}};
    else        r_sync <= {r_sync[0], din};
  end

  assign w_sync = r_sync[1];

  // Any edge that agrees with the held level restarts the count.
  // A bounce therefore never accumulates toward acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (w_sync == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_stable <= w_sync;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign dout = r_stable;
endmodule

// File: rtl/cronometro_input_cond.sv
// Input conditioner that sits between the board pins and the PIO inputs.
// Each of the four slide switches is synchronised and debounced.
// The play button is normalised to active-high and debounced. Its press
// produces a one-cycle play_evt, and play_btn is stretched to at least
// STRETCH_CYCLES so that polling firmware cannot miss a short press.
// Every output is a flop.
// Ports:
//   clk   : system clock, 50 MHz
//   reset : asynchronous, active-low
//   bus   : slave side of the pin/PIO bundle
module cronometro_input_cond
  import cronometro_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int STRETCH_CYCLES  = STRETCH_CYCLES_DEF,
  parameter bit BTN_ACTIVE_LOW  = BTN_ACTIVE_LOW_DEF
) (
  input  logic clk,
  input  logic reset,
  cronometro_input_cond_if.slave bus
);
  localparam int            SW_W      = cnt_w(STRETCH_CYCLES);
  localparam logic [SW_W-1:0] SCNT_LOAD = SW_W'(STRETCH_CYCLES - 1);

  logic [NUM_SW-1:0] w_sw_raw;
  logic [NUM_SW-1:0] w_sw_db;
  logic              w_btn_in;
  logic              w_pressed;
  logic              w_rise;

  logic              r_pressed_d;
  logic [SW_W-1:0]   r_scnt;
  logic              r_play_btn;
  logic              r_play_evt;

  assign w_sw_raw = {bus.sw_pio_raw, bus.sw_pause_raw, bus.sw_mode1_raw, bus.sw_mode0_raw};

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (1'b0)
  ) u_sw [NUM_SW-1:0] (
    .clk  (clk),
    .reset(reset),
    .din  (w_sw_raw),
    .dout (w_sw_db)
  );

  // The button is inverted before synchronisation, so every later stage sees
  // active-high "pressed". A released button therefore resets to 0 here.
  assign w_btn_in = BTN_ACTIVE_LOW ? ~bus.btn_play_raw : bus.btn_play_raw;

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (1'b0)
  ) u_btn (
    .clk  (clk),
    .reset(reset),
    .din  (w_btn_in),
    .dout (w_pressed)
  );

  // The delayed copy resets to 0, which matches the reset value of the
  // debounced level. Reset release therefore cannot look like a press.
  assign w_rise = w_pressed & ~r_pressed_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pressed_d <= 1'b0;
      r_scnt      <= '0;
      r_play_btn  <= 1'b0;
      r_play_evt  <= 1'b0;
    end else begin
      r_pressed_d <= w_pressed;
      r_play_evt  <= w_rise;
      if (w_rise) begin
        // A new press reloads the stretch even while one is still running.
        // play_btn stays high with no gap.
        r_play_btn <= 1'b1;
        r_scnt     <= SCNT_LOAD;
      end else begin
        if (r_scnt != '0) r_scnt <= r_scnt - 1'b1;
        if (r_scnt == '0 && !w_pressed) r_play_btn <= 1'b0;
      end
    end
  end

  assign bus.switch_mode0 = w_sw_db[0];
  assign bus.switch_mode1 = w_sw_db[1];
  assign bus.switch_pause = w_sw_db[2];
  assign bus.pio_switch   = w_sw_db[3];
  assign bus.play_btn     = r_play_btn;
  assign bus.play_evt     = r_play_evt;
endmodule
